// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and the
// queued command record.
package alu_cmd_sequencer_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    typedef struct packed {
        op_t              op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } cmd_t;

    function automatic logic is_div_zero(input op_t op, input logic [ALU_W-1:0] b);
        return (op == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the command, unit-side and response signals of the sequencer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// valid and its payload stay stable until that edge, and ready may depend on nothing upstream.
interface alu_cmd_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    import alu_cmd_sequencer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_sel;
    logic             alu_en;
    logic [2*W-1:0]   alu_res;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2*W-1:0]   rsp_data;
    logic [1:0]       rsp_op;
    logic             rsp_dz;
    logic [CNT_W-1:0] fifo_count;
    state_t           dbg_state;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, alu_res, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_en,
               rsp_valid, rsp_data, rsp_op, rsp_dz, fifo_count, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_res, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_en,
               rsp_valid, rsp_data, rsp_op, rsp_dz, fifo_count, dbg_state
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is read combinationally.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rptr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued commands one at a time to a registered arithmetic unit and
// returns each captured result with its opcode and divide-by-zero flag.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int CMD_W = $bits(cmd_t);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t         state_q;
    state_t         state_d;
    cmd_t           in_cmd;
    cmd_t           head;
    cmd_t           cur_q;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CNT_W-1:0] count;
    logic           push;
    logic           pop;
    logic           en;
    logic           valid;
    logic [2*W-1:0] data_q;
    op_t            op_q;
    logic           dz_q;

    assign in_cmd = '{op: op_t'(bus.cmd_op), a: bus.cmd_a, b: bus.cmd_b};
    assign push   = bus.cmd_valid && !fifo_full;

    alu_cmd_fifo #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en    = 1'b0;
        valid = 1'b0;
        pop   = 1'b0;
        case (state_q)
            ST_IDLE:  pop   = !fifo_empty;
            ST_ISSUE: en    = 1'b1;
            ST_RESP:  valid = 1'b1;
            default:  ;
        endcase
    end

    // The unit clears on the WAIT closing edge; this capture sees its pre-edge result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= '0;
            data_q <= '0;
            op_q   <= OP_ADD;
            dz_q   <= 1'b0;
        end else begin
            if (pop) cur_q <= head;
            if (state_q == ST_WAIT) begin
                data_q <= bus.alu_res;
                op_q   <= cur_q.op;
                dz_q   <= is_div_zero(cur_q.op, cur_q.b);
            end
        end
    end

    assign bus.alu_a      = cur_q.a;
    assign bus.alu_b      = cur_q.b;
    assign bus.alu_sel    = cur_q.op;
    assign bus.alu_en     = en;
    assign bus.rsp_valid  = valid;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_op     = op_q;
    assign bus.rsp_dz     = dz_q;
    assign bus.cmd_ready  = !fifo_full;
    assign bus.fifo_count = count;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: models the registered arithmetic unit and
// scoreboards every response against an arithmetic reference.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_cmd_sequencer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [18:0] exp_q[$];
    logic [15:0] unit_q[$];
    int          accept_cyc[$];
    logic [15:0] unit_calc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Reference: {op, dz, result} from plain arithmetic on the pushed operands.
    function automatic logic [18:0] golden(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        logic dz;
        dz = (op == 2'd3) && (b == 8'd0);
        case (op)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a) * int'(b);
            default: r = (b == 8'd0) ? 32'h0000_FFFF : int'(a) / int'(b);
        endcase
        return {op, dz, r[15:0]};
    endfunction

    // Arithmetic unit: one-cycle registered result, cleared whenever not enabled.
    always_comb begin
        unit_calc = 16'h0000;
        case (bus.alu_sel)
            2'b00: unit_calc = {8'd0, bus.alu_a} + {8'd0, bus.alu_b};
            2'b01: unit_calc = {8'd0, bus.alu_a} - {8'd0, bus.alu_b};
            2'b10: unit_calc = {8'd0, bus.alu_a} * {8'd0, bus.alu_b};
            2'b11: unit_calc = (bus.alu_b == 8'd0) ? 16'hFFFF : {8'd0, bus.alu_a} / {8'd0, bus.alu_b};
            default: unit_calc = 16'h0000;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_res <= 16'h0000;
        end else if (bus.alu_en) begin
            bus.alu_res <= unit_calc;
            unit_q.push_back(unit_calc);
        end else begin
            bus.alu_res <= 16'h0000;
        end
    end

    // Monitor: record accepted commands, compare every presented response.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp got=%h exp=none at cycle %0d", bus.rsp_data, cyc);
                end else begin
                    check("rsp", {13'd0, bus.rsp_op, bus.rsp_dz, bus.rsp_data}, {13'd0, exp_q[0]});
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        accept_cyc.push_back(cyc);
                        if (unit_q.size() == 0) check("unit_track", 32'd0, 32'd1);
                        else check("rsp_eq_unit", {16'd0, bus.rsp_data}, {16'd0, unit_q.pop_front()});
                    end
                end
            end
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back(golden(bus.cmd_op, bus.cmd_a, bus.cmd_b));
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus.rsp_valid) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic wait_rsp_valid(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_rsp_valid", bus.rsp_valid, 1'b1);
    endtask

    initial begin
        int accepts;
        bit done;
        bit got_any;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_alu_en", bus.alu_en, 1'b0);
        check("rst_fifo_count", bus.fifo_count, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_state", bus.dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single ADD with exact latency
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b00;
        bus.cmd_a = 8'd200;
        bus.cmd_b = 8'd100;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("add_en_T", bus.alu_en, 1'b0);
        @(negedge clk);
        check("add_en_T1", bus.alu_en, 1'b1);
        check("add_alu_a", bus.alu_a, 32'd200);
        check("add_alu_b", bus.alu_b, 32'd100);
        check("add_alu_sel", bus.alu_sel, 32'd0);
        @(negedge clk);
        check("add_en_T2", bus.alu_en, 1'b0);
        check("add_valid_T2", bus.rsp_valid, 1'b0);
        @(negedge clk);
        check("add_valid_T3", bus.rsp_valid, 1'b1);
        check("add_data", bus.rsp_data, 32'h012C);
        check("add_dz", bus.rsp_dz, 1'b0);
        wait_drain(100);

        // Back-to-back SUB, MUL, DIV-by-zero
        @(posedge clk);
        #1;
        accept_cyc.delete();
        push_cmd(2'b01, 8'd5, 8'd9);
        push_cmd(2'b10, 8'd15, 8'd17);
        push_cmd(2'b11, 8'd100, 8'd0);
        wait_drain(100);
        check("b2b_count", accept_cyc.size(), 32'd3);
        if (accept_cyc.size() >= 3) begin
            check("b2b_gap0", accept_cyc[1] - accept_cyc[0], 32'd4);
            check("b2b_gap1", accept_cyc[2] - accept_cyc[1], 32'd4);
        end

        // Backpressure: DEPTH+2 offered, DEPTH+1 taken
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op = 2'($urandom_range(0, 3));
            bus.cmd_a = 8'($urandom_range(0, 255));
            bus.cmd_b = 8'($urandom_range(1, 255));
            @(negedge clk);
            if (bus.cmd_ready) accepts++;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepts", accepts, DEPTH + 1);
        repeat (4) @(negedge clk);
        check("bp_cmd_ready", bus.cmd_ready, 1'b0);
        check("bp_fifo_count", bus.fifo_count, DEPTH);
        check("bp_rsp_valid", bus.rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain(200);

        // Push in the same cycle as a pop with one entry queued
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        push_cmd(2'b10, 8'd7, 8'd9);
        push_cmd(2'b00, 8'd33, 8'd44);
        wait_rsp_valid(50);
        check("pp_count_before", bus.fifo_count, 32'd1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 2'b01;
        bus.cmd_a = 8'd3;
        bus.cmd_b = 8'd250;
        @(negedge clk);
        check("pp_idle_state", bus.dbg_state, ST_IDLE);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("pp_count_after", bus.fifo_count, 32'd1);
        wait_drain(100);

        // Random traffic with random backpressure
        done = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                             ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        wait_drain(1000);

        // Reset while a response is stalled and commands are queued
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        push_cmd(2'b10, 8'd12, 8'd3);
        push_cmd(2'b00, 8'd1, 8'd1);
        push_cmd(2'b01, 8'd9, 8'd9);
        wait_rsp_valid(50);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_alu_en", bus.alu_en, 1'b0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("mid_rst_fifo_count", bus.fifo_count, 32'd0);
        exp_q.delete();
        unit_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        got_any = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) got_any = 1'b1;
        end
        check("no_rsp_after_rst", got_any, 1'b0);
        check("leftover_exp", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side controller for the registered 8-bit arithmetic unit: ADD, SUB, MUL and DIV selected by a 2-bit select, with one-cycle registered 16-bit result and clear-on-disable.
- Buffers operation commands from a valid/ready upstream in a small FIFO.
- Drives the unit's operand, select and enable inputs one command at a time.
- Captures the 16-bit result at the correct cycle and returns it downstream on a valid/ready response channel, with opcode and a divide-by-zero flag.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- W, 8, operand width; result width is 2*W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  upstream command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
- cmd_a  in  W  operand a.
- cmd_b  in  W  operand b.
- alu_a  out  W  to unit operand a.
- alu_b  out  W  to unit operand b.
- alu_sel  out  2  to unit select.
- alu_en  out  1  to unit enable.
- alu_res  in  2W  from unit registered result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  2W  captured result.
- rsp_op  out  2  opcode of the response.
- rsp_dz  out  1  1 when op=11 and b=0.
- fifo_count  out  log2(DEPTH)+1  commands queued, excluding the one in flight.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, FSM=IDLE. All outputs 0 except cmd_ready=1.
- Command FIFO:
  - Push on cmd_valid&cmd_ready.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Full means cmd_ready=0; a push attempted while full is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: alu_en=0. If FIFO non-empty, latch the head into the operand/op registers, pop, go to ISSUE.
  - ISSUE: alu_en=1; alu_a/alu_b/alu_sel come from the latched registers. Always go to WAIT. The unit registers its result on this cycle's closing edge.
  - WAIT: alu_en=0; alu_res now holds the result. At the closing edge, capture alu_res into rsp_data, latched op into rsp_op, and the dz flag; set rsp_valid=1; go to RESP. The unit clears on that same edge; the capture samples the pre-edge value.
  - RESP: rsp_valid=1 and all rsp_* fields stable until rsp_valid&rsp_ready. On accept: rsp_valid=0 next cycle, go to IDLE.
- alu_a/alu_b/alu_sel hold their last values outside ISSUE. Only alu_en qualifies them.
- Latency: command pushed at edge T into an empty FIFO with FSM in IDLE:
  - pop at T+1,
  - ISSUE cycle T+1..T+2,
  - rsp_valid high after edge T+3.
  - Steady-state throughput is 1 result per 4 cycles when rsp_ready=1.
- Strictly one command in flight. No overlapping issue.
- rsp_dz is computed from the latched op/b. The result is still forwarded unchanged.
- rst asserted mid-operation (any state): immediate return to the reset state. Any in-flight or queued command is dropped, and alu_en drops asynchronously.
- rsp_ready held 0 indefinitely: FSM stays in RESP. The FIFO keeps accepting until full, then cmd_ready=0.

Decomposition:
- Shared package: opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11), FSM state encoding (IDLE, ISSUE, WAIT, RESP), and a command record {op, a, b} of 2+2W bits.
- One sub-module: alu_cmd_fifo, a parameterised synchronous FIFO (DEPTH, width 2+2W) with full/empty/count and async active-high reset.
- The FSM, capture registers and dz logic live in the top module.

Test Plan:
- Reset: assert rst mid-RESP -> rsp_valid=0, alu_en=0, cmd_ready=1, fifo_count=0 immediately without waiting for a clock; no response after release.
- Single ADD: a=200, b=100, op=00 pushed at T, rsp_ready=1:
  - alu_en=1 exactly one cycle (T+1..T+2);
  - rsp_valid after edge T+3 with rsp_data=16'h012C, rsp_op=00, rsp_dz=0.
- Back-to-back: push SUB 5-9, MUL 15*17, DIV 100/0 on consecutive cycles:
  - responses arrive in order, 4 cycles apart;
  - MUL rsp_data=16'h00FF;
  - DIV rsp_dz=1;
  - rsp_data equals the unit's output from the preceding cycle.
- Backpressure: rsp_ready=0, push DEPTH+2 commands:
  - cmd_ready falls after 1+DEPTH accepts (1 in RESP, DEPTH queued);
  - fifo_count=DEPTH;
  - rsp fields stable while stalled;
  - releasing rsp_ready drains all commands in order.
- Simultaneous push/pop: FIFO holding 1 entry, FSM in IDLE, push in the same cycle as the pop -> fifo_count stays 1 and the next response order is preserved.
